// File: rtl/hw_cpu_oci_mem_sequencer_pkg.sv
// Shared op codes, FSM states and constants for the OCI memory sequencer.
package hw_cpu_oci_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    OpLoad  = 2'd0,
    OpWrite = 2'd1,
    OpRead  = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StWreq   = 3'd2,
    StRreq   = 3'd3,
    StRwait  = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_RD_BIT   = 17;

  // Queue entry layout, MSB first: {op, addr_field, data, rd_flag}.
  function automatic int unsigned entry_width(int unsigned addr_w);
    return 2 + addr_w + 32 + 1;
  endfunction

endpackage

// File: rtl/hw_cpu_oci_cmd_fifo.sv
// Synchronous command FIFO; on simultaneous push/pop the head is read before the tail is written.
module hw_cpu_oci_cmd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned PW1 = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW1'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW1'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hw_cpu_oci_mem_sequencer.sv
// Sysclk-side OCI memory sequencer: queues JTAG debug strobes and runs them on a req/gnt/rvalid port.
module hw_cpu_oci_mem_sequencer
  import hw_cpu_oci_mem_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CMDQ_DEPTH  = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  localparam int unsigned JW      = entry_width(ADDR_W);
  localparam logic [7:0]  TMO_CNT = 8'(TIMEOUT_CYC);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tcnt;
  logic [ADDR_W-1:0] r_job_field;
  logic              r_job_rd;
  logic              r_access;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_mon_dreg;
  logic              r_ready;
  logic              r_error;

  logic              w_push;
  logic              w_multi;
  logic [1:0]        w_push_op;
  logic [ADDR_W-1:0] w_push_field;
  logic [31:0]       w_push_data;
  logic              w_push_rd;
  logic [JW-1:0]     w_push_entry;
  logic [JW-1:0]     w_head;
  op_e               w_head_op;
  logic [ADDR_W-1:0] w_head_field;
  logic [31:0]       w_head_data;
  logic              w_head_rd;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;
  logic              w_waiting;
  logic              w_complete;
  logic              w_abort;
  logic              w_err_set;
  logic              w_unused_jdo;

  assign w_push  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                   (take_action_ocimem_a & take_no_action_ocimem_a) |
                   (take_action_ocimem_b & take_no_action_ocimem_a);

  // Fixed priority picks the single strobe that gets queued this cycle.
  always_comb begin
    w_push_op    = OpRead;
    w_push_field = '0;
    w_push_data  = '0;
    w_push_rd    = 1'b0;
    if (take_action_ocimem_a) begin
      w_push_op    = OpLoad;
      w_push_field = jdo[ADDR_W+1:2];
      w_push_rd    = jdo[JDO_RD_BIT];
    end else if (take_action_ocimem_b) begin
      w_push_op   = OpWrite;
      w_push_data = jdo[34:3];
    end
  end

  assign w_push_entry = {w_push_op, w_push_field, w_push_data, w_push_rd};
  assign w_unused_jdo = ^{jdo[JDO_W-1:35], jdo[1:0]};

  assign w_pop  = (r_state == StIdle) && !w_empty;
  assign w_drop = w_push && w_full && !w_pop;

  hw_cpu_oci_cmd_fifo #(
    .DEPTH (CMDQ_DEPTH),
    .WIDTH (JW)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head_op    = op_e'(w_head[JW-1 -: 2]);
  assign w_head_field = w_head[JW-3 -: ADDR_W];
  assign w_head_data  = w_head[32:1];
  assign w_head_rd    = w_head[0];

  assign w_waiting  = (r_state == StWreq) || (r_state == StRreq) || (r_state == StRwait);
  assign w_complete = ((r_state == StWreq) && mem_gnt) ||
                      ((r_state == StRreq) && mem_gnt) ||
                      ((r_state == StRwait) && mem_rvalid);
  // A grant or data arriving in the final watchdog cycle still wins over the abort.
  assign w_abort    = w_waiting && !w_complete && (r_tcnt == TMO_CNT);
  assign w_err_set  = w_drop || w_multi || w_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_tcnt      <= '0;
      r_job_field <= '0;
      r_job_rd    <= 1'b0;
      r_access    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mon_dreg  <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_job_field <= w_head_field;
            r_job_rd    <= w_head_rd;
            case (w_head_op)
              OpLoad: r_state <= StDecode;
              OpWrite: begin
                r_ready     <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_head_data;
                r_tcnt      <= '0;
                r_access    <= 1'b1;
                r_state     <= StWreq;
              end
              default: begin
                r_ready    <= 1'b0;
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= r_addr;
                r_tcnt     <= '0;
                r_access   <= 1'b1;
                r_state    <= StRreq;
              end
            endcase
          end
        end
        StDecode: begin
          r_addr   <= r_job_field;
          r_ready  <= 1'b0;
          r_error  <= 1'b0;
          r_access <= r_job_rd;
          if (r_job_rd) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_job_field;
            r_tcnt     <= '0;
            r_state    <= StRreq;
          end else begin
            r_state <= StDone;
          end
        end
        StWreq: begin
          if (mem_gnt) begin
            r_mem_req  <= 1'b0;
            r_mon_dreg <= r_mem_wdata;
            r_state    <= StDone;
          end
        end
        StRreq: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (mem_rvalid) begin
              r_mon_dreg <= mem_rdata;
              r_state    <= StDone;
            end else begin
              r_state <= StRwait;
            end
          end
        end
        StRwait: begin
          if (mem_rvalid) begin
            r_mon_dreg <= mem_rdata;
            r_state    <= StDone;
          end
        end
        StDone: begin
          if (r_access) r_addr <= r_addr + ADDR_W'(1);
          r_ready <= w_empty && !w_push;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_abort) begin
        r_mem_req  <= 1'b0;
        r_mon_dreg <= TIMEOUT_DATA;
        r_state    <= StDone;
      end else if (w_waiting) begin
        r_tcnt <= r_tcnt + 8'd1;
      end

      if (w_err_set) r_error <= 1'b1;
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign busy          = (r_state != StIdle) || !w_empty;

endmodule
